// File: rtl/nibble_bus_reader.sv
// Nibble bus receiver: waits SETTLE cycles after a load request, samples the
// 4-bit bus, and queues the nibble in a DEPTH-entry FIFO drained via valid/pop.
module nibble_bus_reader #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         load,
    input  logic [3:0]                   bus_in,
    input  logic                         pop,
    output logic [3:0]                   out,
    output logic                         valid,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic                         overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      timer_q, timer_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [3:0]      out_q, out_d;
    logic [3:0]      mem_q [DEPTH];

    logic push, push_ok, pop_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= 4'd0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            out_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            out_q      <= out_d;
        end
    end

    // Storage is not reset; a capture aborted by reset must not write.
    always_ff @(posedge clock) begin
        if (!reset && push_ok)
            mem_q[wr_ptr_q] <= bus_in;
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    if (SETTLE > 0) begin
                        state_d = S_SETTLE;
                        timer_d = 4'(SETTLE);
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_SETTLE: begin
                if (timer_q <= 4'd1) begin
                    state_d = S_CAPTURE;
                    timer_d = 4'd0;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            S_CAPTURE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        push       = (state_q == S_CAPTURE);
        pop_ok     = pop && (count_q != '0);
        // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
        push_ok    = push && ((count_q != CW'(DEPTH)) || pop_ok);
        wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop_ok)
            count_d = count_q + CW'(1);
        else if (pop_ok && !push_ok)
            count_d = count_q - CW'(1);
        overflow_d = overflow_q | (push && !push_ok);
        // Registered head: bypass bus_in when the new entry becomes the head.
        if (count_d == '0)
            out_d = 4'd0;
        else if (push_ok && (wr_ptr_q == rd_ptr_d))
            out_d = bus_in;
        else
            out_d = mem_q[rd_ptr_d];
    end

    always_comb begin
        out      = out_q;
        valid    = (count_q != '0);
        full     = (count_q == CW'(DEPTH));
        count    = count_q;
        busy     = (state_q != S_IDLE);
        overflow = overflow_q;
    end
endmodule

// File: tb/tb_nibble_bus_reader.sv
// Bench for nibble_bus_reader: two instances (SETTLE=1 and SETTLE=3) checked
// every cycle against a queue-based model of the capture/FIFO behaviour.
module tb_nibble_bus_reader;
    logic       clock, reset, load, pop_a, pop_b;
    logic [3:0] bus_in;
    logic [3:0] out_a, out_b;
    logic       valid_a, valid_b, full_a, full_b, busy_a, busy_b, ovf_a, ovf_b;
    logic [2:0] count_a, count_b;

    int total = 0;
    int bad   = 0;

    logic [3:0] qa[$];
    logic [3:0] qb[$];
    bit  pend_a = 0, pend_b = 0, mo_a = 0, mo_b = 0;
    int  rem_a = 0, rem_b = 0;

    nibble_bus_reader #(.DEPTH(4), .SETTLE(1)) dut_a (
        .clock(clock), .reset(reset), .load(load), .bus_in(bus_in), .pop(pop_a),
        .out(out_a), .valid(valid_a), .full(full_a), .count(count_a),
        .busy(busy_a), .overflow(ovf_a));

    nibble_bus_reader #(.DEPTH(4), .SETTLE(3)) dut_b (
        .clock(clock), .reset(reset), .load(load), .bus_in(bus_in), .pop(pop_b),
        .out(out_b), .valid(valid_b), .full(full_b), .count(count_b),
        .busy(busy_b), .overflow(ovf_b));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: a pending capture fires 'rem' edges after the load edge.
    task automatic model_edge(input int s, input bit ld, input logic [3:0] bus, input bit pp,
                              input bit rst, inout logic [3:0] q[$], inout bit pend,
                              inout int rem, inout bit ovf);
        bit cap;
        if (rst) begin
            q.delete();
            pend = 0; rem = 0; ovf = 0;
        end else begin
            cap = pend && (rem == 0);
            if (pp && q.size() > 0) void'(q.pop_front());
            if (cap) begin
                if (q.size() < 4) q.push_back(bus);
                else ovf = 1;
            end
            if (pend) begin
                if (rem == 0) pend = 0;
                else rem--;
            end else if (ld) begin
                pend = 1; rem = s;
            end
        end
    endtask

    task automatic chk_dut(input string nm, input logic [3:0] q[$], input bit pend, input bit ovf,
                           input logic [3:0] o, input logic v, input logic [2:0] c,
                           input logic f, input logic b, input logic ov);
        logic [3:0] head;
        head = (q.size() > 0) ? q[0] : 4'h0;
        chk({nm, ".out"},      8'(o),  8'(head));
        chk({nm, ".valid"},    8'(v),  8'(q.size() > 0));
        chk({nm, ".count"},    8'(c),  8'(q.size()));
        chk({nm, ".full"},     8'(f),  8'(q.size() == 4));
        chk({nm, ".busy"},     8'(b),  8'(pend));
        chk({nm, ".overflow"}, 8'(ov), 8'(ovf));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge(1, load, bus_in, pop_a, reset, qa, pend_a, rem_a, mo_a);
        model_edge(3, load, bus_in, pop_b, reset, qb, pend_b, rem_b, mo_b);
        #1;
        chk_dut("a", qa, pend_a, mo_a, out_a, valid_a, count_a, full_a, busy_a, ovf_a);
        chk_dut("b", qb, pend_b, mo_b, out_b, valid_b, count_b, full_b, busy_b, ovf_b);
    endtask

    task automatic do_reset();
        reset = 1; load = 0; pop_a = 0; pop_b = 0;
        step(); step();
        reset = 0;
    endtask

    task automatic cap(input logic [3:0] v);
        bus_in = v; load = 1;
        step();
        load = 0;
        repeat (5) step();
    endtask

    task automatic pop_both(input int n);
        pop_a = 1; pop_b = 1;
        repeat (n) step();
        pop_a = 0; pop_b = 0;
    endtask

    initial begin
        reset = 1; load = 0; pop_a = 0; pop_b = 0; bus_in = 4'h0;
        do_reset();

        // single capture then pop
        cap(4'hA);
        chk("single.out_a", 8'(out_a), 8'hA);
        pop_both(1);
        step();

        // settle window: loads held through SETTLE, bus changes just before E4
        do_reset();
        bus_in = 4'h5; load = 1;
        repeat (4) step();
        bus_in = 4'h9; load = 0;
        step();
        chk("settle.out_b", 8'(out_b), 8'h9);
        chk("settle.count_b", 8'(count_b), 8'h1);
        repeat (3) step();

        // fill and wrap
        do_reset();
        cap(4'h1); cap(4'h2); cap(4'h3); cap(4'h4);
        chk("fill.full_a", 8'(full_a), 8'h1);
        pop_both(2);
        cap(4'h5); cap(4'h6);
        pop_both(5);

        // overflow is sticky
        do_reset();
        cap(4'h1); cap(4'h2); cap(4'h3); cap(4'h4);
        cap(4'hF);
        chk("ovf.flag_b", 8'(ovf_b), 8'h1);
        pop_both(3);
        step();

        // pop on the capture edge while full
        do_reset();
        cap(4'h1); cap(4'h2); cap(4'h3); cap(4'h4);
        bus_in = 4'h7; load = 1;
        step();
        load = 0;
        step();
        pop_a = 1; step(); pop_a = 0;
        step();
        pop_b = 1; step(); pop_b = 0;
        chk("simul.ovf_b", 8'(ovf_b), 8'h0);
        step();
        pop_both(5);

        // reset during SETTLE aborts the capture
        do_reset();
        cap(4'h3);
        bus_in = 4'hC; load = 1;
        step();
        load = 0; reset = 1;
        step();
        reset = 0;
        repeat (5) step();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            load   = ($urandom_range(0, 9) < 3);
            pop_a  = ($urandom_range(0, 9) < 3);
            pop_b  = pop_a;
            reset  = ($urandom_range(0, 99) < 2);
            bus_in = 4'($urandom);
            step();
        end
        reset = 0; load = 0; pop_a = 0; pop_b = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nibble_bus_reader.md
# nibble_bus_reader

Receiving end of the Nibbler shared 4-bit data bus. Tri-state drivers place a nibble on the bus; this block waits a programmable settle interval after a load request, samples the bus, and queues the nibble in a small FIFO. The consumer (ALU operand register or output port) drains the FIFO with a valid/pop handshake.

## Interface

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- SETTLE, 1, extra cycles between load acceptance and bus sample; 0..15.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture request; honoured only in IDLE.
- bus_in  input  4  shared data bus, driven by tri-state buffers.
- pop  input  1  consumer removes head entry.
- out  output  4  head entry; 4'b0000 when empty.
- valid  output  1  FIFO non-empty.
- full  output  1  count == DEPTH.
- count  output  $clog2(DEPTH+1)  entries held.
- busy  output  1  state != IDLE.
- overflow  output  1  sticky; a capture was dropped because the FIFO was full.

## Operation

- The FSM has three states: IDLE, SETTLE, CAPTURE.
  - IDLE: on load=1, go to SETTLE with timer=SETTLE if SETTLE>0, otherwise go directly to CAPTURE.
  - SETTLE: decrement the timer each cycle. When the timer reaches 1, go to CAPTURE on the next edge.
  - CAPTURE: sample bus_in on this edge, push it to the FIFO, and return to IDLE. Back-to-back operation: load must be asserted again in a later IDLE cycle.
- load in SETTLE or CAPTURE is ignored. It is not queued.
- FIFO:
  - Circular buffer with rd/wr pointers of width log2(DEPTH); pointers wrap from DEPTH-1 to 0.
  - Push and pop in the same cycle:
    - Non-empty, non-full: both happen, count unchanged.
    - Full: the pop frees the slot, the push succeeds, count stays DEPTH, overflow is not set.
    - Empty: only the push happens; pop on empty is ignored.
  - Push while full without pop: data is dropped, overflow is set to 1 and stays 1 until reset.
  - Pop while empty: ignored; pointers and count are unchanged.
- out is registered head data: it equals mem[rd_ptr] when valid, otherwise 4'b0000.
- bus_in is used only on the CAPTURE edge. Z or X on bus_in in other cycles has no effect.

## Timing

- Reset (synchronous, takes priority over everything):
  - State IDLE, timer 0, pointers 0.
  - count 0, valid 0, full 0, busy 0, overflow 0, out 4'b0000.
  - FIFO contents are don't-care.
- Latency: load sampled at edge E0, then bus_in is sampled at edge E0+SETTLE+1.
  - valid and out update on that same edge (visible in the following cycle).
  - SETTLE=0 gives a 1-edge capture latency.
- busy is 1 from the edge after E0 through the CAPTURE cycle, and 0 again the cycle after the sample edge.
- pop takes effect on the edge where it is sampled with valid=1. The next head (or 0) appears after that edge.
- reset asserted in SETTLE or CAPTURE aborts the capture: nothing is pushed and state returns to IDLE.
- full and count are combinational from registered state. They never glitch relative to the clock edge.

## Test plan

- Reset, then single capture. Defaults (SETTLE=1). Drive bus_in=4'hA, pulse load at E0.
  - Expected: busy=1 for 2 cycles.
  - Expected: bus sampled at E2, then valid=1, out=4'hA, count=1.
  - Then pop: valid=0, out=4'h0, count=0.
- Settle window. SETTLE=3. bus_in=4'h5 until E3, then 4'h9 at the E4 sample.
  - Expected: captured value is 4'h9, proving the sample lands at E0+SETTLE+1.
  - Expected: load pulses at E1..E3 are ignored, and count ends at 1.
- Fill and wrap. DEPTH=4. Capture 4'h1, 4'h2, 4'h3, 4'h4.
  - Expected: full=1, count=4.
  - Pop twice, capture 4'h5 and 4'h6 (pointers wrap), then pop all.
  - Expected order out: 3, 4, 5, 6; overflow=0.
- Overflow. With full=1 and no pop, capture 4'hF.
  - Expected: overflow=1, count=4, contents unchanged.
  - Expected: overflow stays 1 through subsequent pops until reset.
- Simultaneous push/pop while full. Full with 1,2,3,4; pop asserted on the CAPTURE edge of 4'h7.
  - Expected: count stays 4, overflow stays 0, and drain order is 2, 3, 4, 7.
- Reset mid-operation. Assert reset during SETTLE.
  - Expected: next cycle busy=0, count=0, valid=0, out=0, and no push occurs.
